// File: rtl/cpu_loader_pkg.sv
// Shared types and constants for the CPU program loader: state encoding, default sizes and
// the two CPU opcodes (the bench uses the opcodes too).
package cpu_loader_pkg;

  localparam int DATA_WIDTH_DEF     = 10;
  localparam int MEM_DEPTH_DEF      = 8;
  localparam int ADDR_WIDTH_DEF     = 3;
  localparam int TIMEOUT_CYCLES_DEF = 255;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_NOT = 1'b1;

  typedef enum logic [2:0] {
    LD_INSTR,
    LD_DATA,
    START,
    RUN,
    DUMP_RD,
    DUMP_CAP,
    DUMP_OUT
  } loader_state_e;

endpackage

// File: rtl/cpu_loader_wdog.sv
// Run watchdog for the program loader: counts enabled cycles since the last clear and flags the
// cycle that completes TIMEOUT_CYCLES of them. Only built when LOADER_TIMEOUT_EN is defined.
module cpu_loader_wdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // count holds the RUN cycles already completed, so a match here marks the final allowed cycle
  assign expired = en && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/cpu_program_loader.sv
// Host-side loader for the 8-entry FSM CPU: loads instruction/data memory, starts the CPU, waits
// for completion and streams data memory back out. Optional run watchdog: define LOADER_TIMEOUT_EN.
module cpu_program_loader
  import cpu_loader_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int MEM_DEPTH      = MEM_DEPTH_DEF,
  parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  im_wr_en,
  output logic [ADDR_WIDTH-1:0] im_wr_addr,
  output logic [DATA_WIDTH-1:0] im_wr_data,
  output logic [ADDR_WIDTH-1:0] dm_addr,
  output logic                  dm_wr_en,
  output logic                  dm_rd_en,
  output logic [7:0]            dm_wr_data,
  input  logic [7:0]            dm_rd_data,
  output logic                  mem_owner,
  output logic                  cpu_start,
  input  logic                  cpu_done,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [7:0]            m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  err_timeout
);

  // one spare bit so the MEM_DEPTH-1 compare never depends on wrap-around
  localparam int CW = ADDR_WIDTH + 1;

  loader_state_e state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          mem_owner_n;
  logic          m_valid_n;
  logic [7:0]    m_data_n;
  logic          m_last_n;
  logic          busy_n;
  logic          err_timeout_n;
  logic          last_word;
  logic          wdog_clr;
  logic          wdog_en;
  logic          wdog_expired;

  assign last_word = (cnt == CW'(MEM_DEPTH - 1));

`ifdef LOADER_TIMEOUT_EN
  cpu_loader_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (wdog_clr),
    .en     (wdog_en),
    .expired(wdog_expired)
  );
`else
  logic unused_wdog;
  assign unused_wdog  = ^{wdog_clr, wdog_en, (TIMEOUT_CYCLES != 0)};
  assign wdog_expired = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= LD_INSTR;
      cnt         <= '0;
      mem_owner   <= 1'b1;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_last      <= 1'b0;
      busy        <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      mem_owner   <= mem_owner_n;
      m_valid     <= m_valid_n;
      m_data      <= m_data_n;
      m_last      <= m_last_n;
      busy        <= busy_n;
      err_timeout <= err_timeout_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    mem_owner_n   = mem_owner;
    m_valid_n     = m_valid;
    m_data_n      = m_data;
    m_last_n      = m_last;
    busy_n        = busy;
    err_timeout_n = err_timeout;
    s_ready       = 1'b0;
    im_wr_en      = 1'b0;
    im_wr_addr    = cnt[ADDR_WIDTH-1:0];
    im_wr_data    = s_data;
    dm_addr       = cnt[ADDR_WIDTH-1:0];
    dm_wr_en      = 1'b0;
    dm_rd_en      = 1'b0;
    dm_wr_data    = s_data[7:0];
    cpu_start     = 1'b0;
    wdog_clr      = 1'b0;
    wdog_en       = 1'b0;

    case (state)
      LD_INSTR: begin
        s_ready = 1'b1;
        if (s_valid) begin
          im_wr_en = 1'b1;
          // a fresh load acknowledges any earlier watchdog trip
          if (cnt == '0) err_timeout_n = 1'b0;
          if (last_word) begin
            cnt_n   = '0;
            state_n = LD_DATA;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end

      LD_DATA: begin
        s_ready = 1'b1;
        if (s_valid) begin
          dm_wr_en = 1'b1;
          if (last_word) begin
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = START;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end

      START: begin
        cpu_start   = 1'b1;
        wdog_clr    = 1'b1;
        mem_owner_n = 1'b0;
        state_n     = RUN;
      end

      RUN: begin
        wdog_en = 1'b1;
        // completion takes priority over a watchdog trip in the same cycle
        if (cpu_done) begin
          mem_owner_n = 1'b1;
          cnt_n       = '0;
          state_n     = DUMP_RD;
        end else if (wdog_expired) begin
          err_timeout_n = 1'b1;
          mem_owner_n   = 1'b1;
          cnt_n         = '0;
          state_n       = DUMP_RD;
        end
      end

      DUMP_RD: begin
        dm_rd_en = 1'b1;
        state_n  = DUMP_CAP;
      end

      DUMP_CAP: begin
        m_data_n  = dm_rd_data;
        m_valid_n = 1'b1;
        m_last_n  = last_word;
        state_n   = DUMP_OUT;
      end

      DUMP_OUT: begin
        if (m_ready) begin
          m_valid_n = 1'b0;
          if (m_last) begin
            busy_n  = 1'b0;
            cnt_n   = '0;
            state_n = LD_INSTR;
          end else begin
            cnt_n   = cnt + CW'(1);
            state_n = DUMP_RD;
          end
        end
      end

      default: begin
        state_n = LD_INSTR;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader with a behavioural CPU and 1-cycle-latency memories; expected
// dumps come from an arithmetic model of the program and are checked by a handshake monitor.
`timescale 1ns/1ps
module tb_cpu_program_loader;
  import cpu_loader_pkg::*;

  localparam int DW = 10;
  localparam int MD = 8;
  localparam int AW = 3;
  localparam int TO = 20;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
  } dump_t;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          im_wr_en;
  logic [AW-1:0] im_wr_addr;
  logic [DW-1:0] im_wr_data;
  logic [AW-1:0] dm_addr;
  logic          dm_wr_en;
  logic          dm_rd_en;
  logic [7:0]    dm_wr_data;
  logic [7:0]    dm_rd_q;
  logic          mem_owner;
  logic          cpu_start;
  logic          cpu_done;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [7:0]    m_data;
  logic          m_last;
  logic          busy;
  logic          err_timeout;

  // environment: memories and a behavioural CPU
  logic [DW-1:0] im_mem [MD];
  logic [7:0]    dm_mem [MD];
  logic          cpu_run;
  logic [AW-1:0] pc;
  logic          tick;
  logic          cpu_done_cpu;
  logic          cpu_done_force = 1'b0;
  logic          cpu_connect = 1'b1;

  // bench state
  logic [DW-1:0] cur_ins [MD];
  logic [7:0]    cur_dat [MD];
  dump_t         sb_q [$];
  int            errors = 0;
  int            checks = 0;
  int            dumps_done = 0;
  int            im_wr_cnt [MD];
  int            dm_wr_cnt [MD];
  int            start_cnt = 0;
  int            vmode = 0;
  int            rmode = 0;
  bit            tog = 1'b0;
  bit            chk_err_clear = 1'b0;
  bit            done_in_lddata = 1'b0;

  always #5 clk = ~clk;

  assign cpu_done = cpu_done_cpu | cpu_done_force;

  cpu_program_loader #(
    .DATA_WIDTH    (DW),
    .MEM_DEPTH     (MD),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .im_wr_en   (im_wr_en),
    .im_wr_addr (im_wr_addr),
    .im_wr_data (im_wr_data),
    .dm_addr    (dm_addr),
    .dm_wr_en   (dm_wr_en),
    .dm_rd_en   (dm_rd_en),
    .dm_wr_data (dm_wr_data),
    .dm_rd_data (dm_rd_q),
    .mem_owner  (mem_owner),
    .cpu_start  (cpu_start),
    .cpu_done   (cpu_done),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .err_timeout(err_timeout)
  );

  // CPU executes one instruction every second cycle, then pulses cpu_done
  always @(posedge clk) begin
    if (mem_owner) begin
      if (im_wr_en) im_mem[im_wr_addr] <= im_wr_data;
      if (dm_wr_en) dm_mem[dm_addr] <= dm_wr_data;
      if (dm_rd_en) dm_rd_q <= dm_mem[dm_addr];
    end
    if (!rstn) begin
      cpu_run      <= 1'b0;
      pc           <= '0;
      tick         <= 1'b0;
      cpu_done_cpu <= 1'b0;
    end else begin
      cpu_done_cpu <= 1'b0;
      if (cpu_start && cpu_connect) begin
        cpu_run <= 1'b1;
        pc      <= '0;
        tick    <= 1'b0;
      end else if (cpu_run) begin
        if (tick) begin
          tick <= 1'b0;
          if (im_mem[pc][0] == OP_ADD)
            dm_mem[im_mem[pc][9:7]] <= dm_mem[im_mem[pc][3:1]] + dm_mem[im_mem[pc][6:4]];
          else
            dm_mem[im_mem[pc][9:7]] <= ~dm_mem[im_mem[pc][3:1]];
          if (pc == AW'(MD - 1)) begin
            cpu_run      <= 1'b0;
            cpu_done_cpu <= 1'b1;
          end else begin
            pc <= pc + AW'(1);
          end
        end else begin
          tick <= 1'b1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // reference: fields decoded arithmetically, program run in order over a plain int array
  function automatic void model_dump(input bit cpu_runs);
    int mem [MD];
    for (int i = 0; i < MD; i++) mem[i] = int'(cur_dat[i]);
    if (cpu_runs) begin
      for (int k = 0; k < MD; k++) begin
        int w, opc, a, b, r;
        w   = int'(cur_ins[k]);
        opc = w % 2;
        a   = (w / 2) % 8;
        b   = (w / 16) % 8;
        r   = (w / 128) % 8;
        if (opc == 0) mem[r] = (mem[a] + mem[b]) % 256;
        else          mem[r] = 255 - mem[a];
      end
    end
    for (int i = 0; i < MD; i++) sb_q.push_back('{d: 8'(mem[i]), last: (i == MD - 1)});
  endfunction

  function automatic int hold_for();
    if (rmode == 1) return 5;
    if (rmode == 2) return int'($urandom_range(0, 2));
    return 0;
  endfunction

  // consumer drives m_ready and monitor checks, both at the falling edge
  initial begin : monitor
    int    stall, hold;
    bit    prev_pend, expect_idle;
    logic [7:0] prev_data;
    logic  prev_last;
    dump_t exp_w;
    stall = 0; hold = 0; prev_pend = 0; expect_idle = 0; prev_data = '0; prev_last = 0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        prev_pend   = 0;
        expect_idle = 0;
        stall       = 0;
        m_ready     = 1'b0;
        continue;
      end
      if (mem_owner && im_wr_en) im_wr_cnt[im_wr_addr]++;
      if (mem_owner && dm_wr_en) dm_wr_cnt[dm_addr]++;
      if (cpu_start) begin
        int tot;
        tot = 0;
        for (int a = 0; a < MD; a++) tot += im_wr_cnt[a] + dm_wr_cnt[a];
        start_cnt++;
        check("start_after_16_writes", 32'(tot), 32'd16);
        check("start_busy_owner_ready", {29'd0, busy, mem_owner, s_ready}, {29'd0, 3'b110});
      end
      if (m_valid) begin
        if (stall < hold) begin
          m_ready = 1'b0;
          stall++;
        end else begin
          m_ready = 1'b1;
        end
      end else begin
        stall   = 0;
        hold    = hold_for();
        m_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 0);
      end
      if (prev_pend)
        check("dump_hold_stable", {22'd0, m_valid, m_last, m_data}, {22'd0, 1'b1, prev_last, prev_data});
      if (expect_idle) begin
        check("idle_after_last", {30'd0, busy, m_valid}, 32'd0);
        expect_idle = 0;
      end
      if (m_valid && m_ready) begin
        check("dump_busy", 32'(busy), 32'd1);
        if (sb_q.size() == 0) begin
          check("dump_unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
        end else begin
          exp_w = sb_q.pop_front();
          check("dump_data", 32'(m_data), 32'(exp_w.d));
          check("dump_last", 32'(m_last), 32'(exp_w.last));
        end
        if (m_last) begin
          expect_idle = 1;
          dumps_done++;
        end
        prev_pend = 0;
        stall     = 0;
      end else begin
        prev_pend = m_valid;
      end
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic clear_counts();
    for (int a = 0; a < MD; a++) begin
      im_wr_cnt[a] = 0;
      dm_wr_cnt[a] = 0;
    end
    start_cnt = 0;
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    bit done, acc;
    int guard;
    done = 0;
    guard = 0;
    while (!done && guard < 100) begin
      s_data = w;
      tog = ~tog;
      case (vmode)
        1:       s_valid = tog;
        2:       s_valid = 1'($urandom_range(0, 1));
        default: s_valid = 1'b1;
      endcase
      acc = s_valid && s_ready;
      @(posedge clk); #1;
      done = acc;
      guard++;
    end
    if (!done) check("send_word_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int i = 0; i < 2 * MD; i++) begin
      if (i == MD + 3 && done_in_lddata) begin
        s_valid = 1'b0;
        cpu_done_force = 1'b1;
        @(posedge clk); #1;
        cpu_done_force = 1'b0;
        check("done_in_lddata_ignored",
              {27'd0, s_ready, mem_owner, busy, m_valid, cpu_start}, {27'd0, 5'b11000});
      end
      if (i < MD) send_word(cur_ins[i]);
      else        send_word({2'($urandom), cur_dat[i - MD]});
      if (i == 0 && chk_err_clear) check("err_clear_on_first_accept", 32'(err_timeout), 32'd0);
    end
  endtask

  task automatic wait_dump();
    int d0, n;
    d0 = dumps_done;
    n = 0;
    while (dumps_done == d0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    if (dumps_done == d0) check("dump_complete_timeout", 32'd0, 32'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_counts();
    for (int a = 0; a < MD; a++) begin
      check("im_writes_per_addr", 32'(im_wr_cnt[a]), 32'd1);
      check("dm_writes_per_addr", 32'(dm_wr_cnt[a]), 32'd1);
    end
    check("cpu_start_pulses", 32'(start_cnt), 32'd1);
  endtask

  task automatic run_full(input bit cpu_runs);
    clear_counts();
    model_dump(cpu_runs);
    load_all();
    wait_dump();
    check_counts();
    if (cpu_runs) check("err_timeout_low", 32'(err_timeout), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"},
          {24'd0, s_ready, mem_owner, m_valid, m_last, busy, err_timeout, cpu_start, dm_rd_en},
          {24'd0, 8'b1100_0000});
    check({tag, "_m_data"}, 32'(m_data), 32'd0);
    check({tag, "_writes"}, {30'd0, im_wr_en, dm_wr_en}, 32'd0);
  endtask

  task automatic set_scenario1();
    logic [7:0] d [MD];
    d = '{8'h05, 8'h07, 8'h00, 8'h03, 8'h04, 8'h05, 8'h06, 8'h0F};
    cur_ins[0] = 10'h110;
    for (int i = 1; i < MD; i++) cur_ins[i] = 10'h3FF;
    for (int i = 0; i < MD; i++) cur_dat[i] = d[i];
  endtask

  task automatic set_random();
    for (int i = 0; i < MD; i++) begin
      cur_ins[i] = DW'($urandom);
      cur_dat[i] = 8'($urandom);
    end
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    while (!cpu_start && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cpu_start) check("cpu_start_seen", 32'd0, 32'd1);
  endtask

  initial begin : main
    int n;
    clear_counts();
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b1;

    // fixed program, free-flowing handshakes
    set_scenario1();
    vmode = 0; rmode = 0;
    run_full(1);

    // gapped input stream
    set_random();
    vmode = 1;
    run_full(1);

    // downstream stalls on every dump word
    set_random();
    vmode = 0; rmode = 1;
    run_full(1);

    // stray cpu_done while loading data, random handshakes
    set_random();
    vmode = 2; rmode = 2; done_in_lddata = 1;
    run_full(1);
    done_in_lddata = 0;

    // reset while the CPU is running, then the fixed program again
    set_random();
    vmode = 0; rmode = 0;
    clear_counts();
    load_all();
    n = 0;
    while (mem_owner && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("owner_released_in_run", 32'(mem_owner), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("mid_run_reset");
    sb_q.delete();
    rstn = 1'b1;
    set_scenario1();
    run_full(1);

`ifdef LOADER_TIMEOUT_EN
    // CPU never started: watchdog trips after TO RUN cycles and the untouched data is dumped
    cpu_connect = 1'b0;
    set_random();
    clear_counts();
    model_dump(0);
    load_all();
    wait_start();
    repeat (TO) @(posedge clk);
    #1;
    check("wdog_last_run_cycle", {30'd0, err_timeout, mem_owner}, 32'd0);
    @(posedge clk); #1;
    check("wdog_tripped", {29'd0, err_timeout, mem_owner, dm_rd_en}, {29'd0, 3'b111});
    wait_dump();
    check_counts();
    check("err_timeout_sticky", 32'(err_timeout), 32'd1);

    // cpu_done on the trip cycle wins
    set_random();
    clear_counts();
    model_dump(0);
    chk_err_clear = 1'b1;
    load_all();
    chk_err_clear = 1'b0;
    wait_start();
    repeat (TO) @(posedge clk);
    #1;
    cpu_done_force = 1'b1;
    @(posedge clk); #1;
    cpu_done_force = 1'b0;
    check("done_beats_timeout", {30'd0, err_timeout, mem_owner}, {30'd0, 2'b01});
    wait_dump();
    check_counts();
    cpu_connect = 1'b1;
`endif

    // randomized traffic
    for (int r = 0; r < 3; r++) begin
      set_random();
      vmode = int'($urandom_range(0, 2));
      rmode = int'($urandom_range(0, 2));
      run_full(1);
    end

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
